// File: rtl/uart_pkg.sv
// Shared UART definitions: line levels, data width and the framing state enum.
// Defining UART_TX_PARITY_EN adds the PARITY state for 8E1 framing; the default is 8N1.
package uart_pkg;

    localparam int   DATA_BITS  = 8;
    localparam logic LINE_IDLE  = 1'b1;
    localparam logic LINE_START = 1'b0;
    localparam logic LINE_STOP  = 1'b1;

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } uart_state_t;
`else
    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } uart_state_t;
`endif

    // XOR of all data bits gives the bit that makes the total count of ones even.
    function automatic logic even_parity(input logic [DATA_BITS-1:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period timer shared by the UART transmitter and receiver.
// Counts 0..CLKS_PER_BIT-1 and flags the last cycle of each bit with bit_done.
module uart_baud_gen #(
    parameter int CLKS_PER_BIT = 104
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    output logic bit_done
);

    localparam int              CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] count;

    // Clear realigns the bit period to the cycle after a frame is accepted.
    always_ff @(posedge clock) begin
        if (reset || clear) begin
            count <= '0;
        end else if (count == LAST) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

    assign bit_done = (count == LAST);

endmodule

// File: rtl/uart_transmitter.sv
// UART transmitter: accepts a byte on a valid/ready handshake and shifts it out LSB first.
// Framing is 8N1 by default; defining UART_TX_PARITY_EN inserts an even-parity bit (8E1).
module uart_transmitter
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 104
) (
    input  logic       iCE_CLK,
    input  logic       RESET,
    input  logic [7:0] tx_byte,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       TX,
    output logic       tx_busy
);

    uart_state_t            state;
    uart_state_t            state_next;
    logic [2:0]             bit_idx;
    logic [2:0]             bit_idx_next;
    logic [DATA_BITS-1:0]   shift_reg;
    logic [DATA_BITS-1:0]   shift_next;
    logic                   tx_line;
    logic                   tx_next;
    logic                   accept;
    logic                   baud_clear;
    logic                   bit_done;
`ifdef UART_TX_PARITY_EN
    logic                   parity_bit;
`endif

    uart_baud_gen #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud_gen (
        .clock    (iCE_CLK),
        .reset    (RESET),
        .clear    (baud_clear),
        .bit_done (bit_done)
    );

    assign tx_ready = (state == IDLE);
    assign tx_busy  = ~tx_ready;
    assign accept   = tx_valid & tx_ready;
    assign TX       = tx_line;

    always_ff @(posedge iCE_CLK) begin
        if (RESET) begin
            state     <= IDLE;
            bit_idx   <= '0;
            shift_reg <= '0;
            tx_line   <= LINE_IDLE;
        end else begin
            state     <= state_next;
            bit_idx   <= bit_idx_next;
            shift_reg <= shift_next;
            tx_line   <= tx_next;
        end
    end

`ifdef UART_TX_PARITY_EN
    // Parity is taken from the byte as accepted, before shifting destroys it.
    always_ff @(posedge iCE_CLK) begin
        if (RESET) begin
            parity_bit <= 1'b0;
        end else if (accept) begin
            parity_bit <= even_parity(tx_byte);
        end
    end
`endif

    // tx_next is the line level for the cycle after this edge, so TX stays registered.
    always_comb begin
        state_next   = state;
        bit_idx_next = bit_idx;
        shift_next   = shift_reg;
        tx_next      = tx_line;
        baud_clear   = 1'b0;

        case (state)
            IDLE: begin
                tx_next = LINE_IDLE;
                if (accept) begin
                    state_next   = START;
                    shift_next   = tx_byte;
                    bit_idx_next = '0;
                    baud_clear   = 1'b1;
                    tx_next      = LINE_START;
                end
            end

            START: begin
                if (bit_done) begin
                    state_next = DATA;
                    tx_next    = shift_reg[0];
                end
            end

            DATA: begin
                if (bit_done) begin
                    if (bit_idx == 3'(DATA_BITS - 1)) begin
`ifdef UART_TX_PARITY_EN
                        state_next = PARITY;
                        tx_next    = parity_bit;
`else
                        state_next = STOP;
                        tx_next    = LINE_STOP;
`endif
                    end else begin
                        shift_next   = {1'b0, shift_reg[DATA_BITS-1:1]};
                        bit_idx_next = bit_idx + 3'd1;
                        tx_next      = shift_reg[1];
                    end
                end
            end

`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (bit_done) begin
                    state_next = STOP;
                    tx_next    = LINE_STOP;
                end
            end
`endif

            STOP: begin
                if (bit_done) begin
                    state_next = IDLE;
                    tx_next    = LINE_IDLE;
                end
            end

            default: begin
                state_next = IDLE;
                tx_next    = LINE_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_transmitter.sv
// Self-checking bench for uart_transmitter: a fast instance (4 clocks/bit) and a default-rate instance
// are compared against a frame model built from the UART framing rules.
module tb_uart_transmitter;

    localparam int FAST_CPB = 4;
    localparam int DEF_CPB  = 104;
`ifdef UART_TX_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif
    localparam int FAST_PERIOD = FRAME_BITS * FAST_CPB + 1;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] byte_f = 8'h00;
    logic       valid_f = 1'b0;
    logic       ready_f;
    logic       tx_f;
    logic       busy_f;
    logic [7:0] byte_d = 8'h00;
    logic       valid_d = 1'b0;
    logic       ready_d;
    logic       tx_d;
    logic       busy_d;

    int checks = 0;
    int failures = 0;

    logic tx_log[$];
    logic rdy_log[$];
    logic busy_log[$];

    always #5 clk = ~clk;

    uart_transmitter #(.CLKS_PER_BIT(FAST_CPB)) dut (
        .iCE_CLK  (clk),
        .RESET    (rst),
        .tx_byte  (byte_f),
        .tx_valid (valid_f),
        .tx_ready (ready_f),
        .TX       (tx_f),
        .tx_busy  (busy_f)
    );

    uart_transmitter dut_def (
        .iCE_CLK  (clk),
        .RESET    (rst),
        .tx_byte  (byte_d),
        .tx_valid (valid_d),
        .tx_ready (ready_d),
        .TX       (tx_d),
        .tx_busy  (busy_d)
    );

    // Expected line level for frame bit k: start, data LSB first, optional even parity, stop.
    function automatic logic model_bit(input logic [7:0] b, input int k);
        if (k == 0) return 1'b0;
        if (k <= 8) return b[k-1];
        if (FRAME_BITS == 11 && k == 9) return ^b;
        return 1'b1;
    endfunction

    // Waits for ready on the chosen instance, then offers one byte for exactly one edge.
    task automatic offer(input bit sel, input logic [7:0] b, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if ((sel ? ready_d : ready_f) === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) return;
        if (sel) begin
            valid_d = 1'b1;
            byte_d  = b;
        end else begin
            valid_f = 1'b1;
            byte_f  = b;
        end
        @(posedge clk);
        #1;
        if (sel) valid_d = 1'b0;
        else valid_f = 1'b0;
    endtask

    task automatic capture(input bit sel, input int n);
        tx_log.delete();
        rdy_log.delete();
        busy_log.delete();
        repeat (n) begin
            @(negedge clk);
            tx_log.push_back(sel ? tx_d : tx_f);
            rdy_log.push_back(sel ? ready_d : ready_f);
            busy_log.push_back(sel ? busy_d : busy_f);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (tx_f !== 1'b1 || ready_f !== 1'b1 || busy_f !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_fast: tx/ready/busy got %b%b%b expected 110", tx_f, ready_f, busy_f);
        end
        checks++;
        if (tx_d !== 1'b1 || ready_d !== 1'b1 || busy_d !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_def: tx/ready/busy got %b%b%b expected 110", tx_d, ready_d, busy_d);
        end
        rst = 1'b0;
    endtask

    task automatic test_frames();
        logic [7:0] vals[$];
        bit ok;
        vals.push_back(8'hA5);
        repeat (5) vals.push_back(8'($urandom_range(0, 255)));
        foreach (vals[v]) begin
            offer(1'b0, vals[v], ok);
            checks++;
            if (!ok) begin
                failures++;
                $display("[TB] FAIL frame_offer %h: tx_ready got 0 expected 1", vals[v]);
                continue;
            end
            capture(1'b0, FAST_PERIOD);
            for (int s = 1; s < FAST_PERIOD; s++) begin
                checks++;
                if (tx_log[s-1] !== model_bit(vals[v], (s - 1) / FAST_CPB)) begin
                    failures++;
                    $display("[TB] FAIL frame_tx %h cycle %0d: got %b expected %b",
                             vals[v], s, tx_log[s-1], model_bit(vals[v], (s - 1) / FAST_CPB));
                end
                checks++;
                if (rdy_log[s-1] !== 1'b0 || busy_log[s-1] !== 1'b1) begin
                    failures++;
                    $display("[TB] FAIL frame_busy %h cycle %0d: ready/busy got %b%b expected 01",
                             vals[v], s, rdy_log[s-1], busy_log[s-1]);
                end
            end
            checks++;
            if (rdy_log[FAST_PERIOD-1] !== 1'b1 || tx_log[FAST_PERIOD-1] !== 1'b1) begin
                failures++;
                $display("[TB] FAIL frame_end %h cycle %0d: ready/tx got %b%b expected 11",
                         vals[v], FAST_PERIOD, rdy_log[FAST_PERIOD-1], tx_log[FAST_PERIOD-1]);
            end
        end
    endtask

    task automatic test_back_to_back();
        int acc[$];
        int s;
        logic exp_tx;
        int limit = 3 * FAST_PERIOD + 10;
        valid_f = 1'b1;
        byte_f  = 8'h00;
        for (int cyc = 0; cyc < limit; cyc++) begin
            @(negedge clk);
            if (acc.size() >= 1) begin
                s = cyc - acc[0];
                if (s < FAST_PERIOD) exp_tx = model_bit(8'h00, (s - 1) / FAST_CPB);
                else if (s == FAST_PERIOD) exp_tx = 1'b1;
                else exp_tx = model_bit(8'hFF, (s - FAST_PERIOD - 1) / FAST_CPB);
                checks++;
                if (tx_f !== exp_tx) begin
                    failures++;
                    $display("[TB] FAIL b2b_tx cycle %0d: got %b expected %b", s, tx_f, exp_tx);
                end
            end
            if (acc.size() == 1 && cyc == acc[0] + 1) byte_f = 8'hFF;
            if (acc.size() == 2 && cyc == acc[1] + 1) valid_f = 1'b0;
            if (valid_f && ready_f === 1'b1) acc.push_back(cyc);
            if (acc.size() >= 1 && cyc - acc[0] >= 2 * FAST_PERIOD - 1) break;
        end
        valid_f = 1'b0;
        checks++;
        if (acc.size() != 2) begin
            failures++;
            $display("[TB] FAIL b2b_count: accepts got %0d expected 2", acc.size());
        end else begin
            checks++;
            if (acc[1] - acc[0] != FAST_PERIOD) begin
                failures++;
                $display("[TB] FAIL b2b_spacing: got %0d expected %0d", acc[1] - acc[0], FAST_PERIOD);
            end
        end
    endtask

    task automatic test_ignore_midframe();
        bit ok;
        logic [7:0] b1 = 8'($urandom_range(0, 255));
        offer(1'b0, b1, ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("[TB] FAIL ignore_offer: tx_ready got 0 expected 1");
            return;
        end
        fork
            capture(1'b0, FAST_PERIOD);
            begin
                repeat (10) @(negedge clk);
                byte_f  = ~b1;
                valid_f = 1'b1;
                repeat (4) @(negedge clk);
                byte_f = 8'h5A;
                repeat (4) @(negedge clk);
                valid_f = 1'b0;
            end
        join
        for (int s = 1; s < FAST_PERIOD; s++) begin
            checks++;
            if (tx_log[s-1] !== model_bit(b1, (s - 1) / FAST_CPB)) begin
                failures++;
                $display("[TB] FAIL ignore_tx %h cycle %0d: got %b expected %b",
                         b1, s, tx_log[s-1], model_bit(b1, (s - 1) / FAST_CPB));
            end
        end
        capture(1'b0, 2 * FAST_CPB);
        foreach (tx_log[i]) begin
            checks++;
            if (tx_log[i] !== 1'b1 || rdy_log[i] !== 1'b1) begin
                failures++;
                $display("[TB] FAIL ignore_idle cycle %0d: tx/ready got %b%b expected 11",
                         i, tx_log[i], rdy_log[i]);
            end
        end
    endtask

    task automatic test_reset_midframe();
        bit ok;
        logic [7:0] b1 = 8'($urandom_range(0, 255));
        offer(1'b0, b1, ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("[TB] FAIL rstmid_offer: tx_ready got 0 expected 1");
            return;
        end
        // Samples 17 and 18 fall inside data bit 3 (frame bit 4).
        capture(1'b0, 4 * FAST_CPB + 2);
        checks++;
        if (tx_log[4*FAST_CPB] !== b1[3] || rdy_log[4*FAST_CPB] !== 1'b0) begin
            failures++;
            $display("[TB] FAIL rstmid_bit3: tx/ready got %b%b expected %b0",
                     tx_log[4*FAST_CPB], rdy_log[4*FAST_CPB], b1[3]);
        end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (tx_f !== 1'b1 || ready_f !== 1'b1 || busy_f !== 1'b0) begin
            failures++;
            $display("[TB] FAIL rstmid_abort: tx/ready/busy got %b%b%b expected 110", tx_f, ready_f, busy_f);
        end
        rst = 1'b0;
        offer(1'b0, 8'h3C, ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("[TB] FAIL rstmid_reoffer: tx_ready got 0 expected 1");
            return;
        end
        capture(1'b0, FAST_PERIOD);
        for (int s = 1; s < FAST_PERIOD; s++) begin
            checks++;
            if (tx_log[s-1] !== model_bit(8'h3C, (s - 1) / FAST_CPB)) begin
                failures++;
                $display("[TB] FAIL rstmid_tx 3c cycle %0d: got %b expected %b",
                         s, tx_log[s-1], model_bit(8'h3C, (s - 1) / FAST_CPB));
            end
        end
        checks++;
        if (rdy_log[FAST_PERIOD-1] !== 1'b1) begin
            failures++;
            $display("[TB] FAIL rstmid_ready: got %b expected 1", rdy_log[FAST_PERIOD-1]);
        end
    endtask

    task automatic test_reset_priority();
        @(negedge clk);
        rst     = 1'b1;
        valid_f = 1'b1;
        byte_f  = 8'h00;
        @(negedge clk);
        checks++;
        if (tx_f !== 1'b1 || ready_f !== 1'b1) begin
            failures++;
            $display("[TB] FAIL rstprio_edge: tx/ready got %b%b expected 11", tx_f, ready_f);
        end
        rst     = 1'b0;
        valid_f = 1'b0;
        capture(1'b0, FAST_CPB);
        foreach (tx_log[i]) begin
            checks++;
            if (tx_log[i] !== 1'b1) begin
                failures++;
                $display("[TB] FAIL rstprio_idle cycle %0d: tx got %b expected 1", i, tx_log[i]);
            end
        end
    endtask

    task automatic test_parity();
        bit ok;
        logic [7:0] pv[2] = '{8'h07, 8'h03};
`ifdef UART_TX_PARITY_EN
        logic exp_p[2] = '{1'b1, 1'b0};
        int   bit9_idx = 9 * FAST_CPB + FAST_CPB / 2;
`else
        logic exp_p[2] = '{1'b1, 1'b1};
        int   bit9_idx = 9 * FAST_CPB + FAST_CPB / 2;
`endif
        for (int j = 0; j < 2; j++) begin
            offer(1'b0, pv[j], ok);
            checks++;
            if (!ok) begin
                failures++;
                $display("[TB] FAIL parity_offer %h: tx_ready got 0 expected 1", pv[j]);
                continue;
            end
            capture(1'b0, FAST_PERIOD);
            checks++;
            if (tx_log[bit9_idx] !== exp_p[j]) begin
                failures++;
                $display("[TB] FAIL parity_bit9 %h: got %b expected %b", pv[j], tx_log[bit9_idx], exp_p[j]);
            end
            checks++;
            if (rdy_log[FAST_PERIOD-2] !== 1'b0 || rdy_log[FAST_PERIOD-1] !== 1'b1) begin
                failures++;
                $display("[TB] FAIL parity_length %h: ready at %0d/%0d got %b%b expected 01",
                         pv[j], FAST_PERIOD - 1, FAST_PERIOD, rdy_log[FAST_PERIOD-2], rdy_log[FAST_PERIOD-1]);
            end
        end
    endtask

    // Decodes each frame by sampling the middle of every bit, as an asynchronous receiver would.
    task automatic test_loopback(input bit sel, input int cpb, input int count);
        bit ok;
        logic [7:0] val;
        logic [7:0] rx;
        for (int n = 0; n < count; n++) begin
            val = (count == 256) ? 8'(n) : 8'($urandom_range(0, 255));
            if (count != 256 && n == 0) val = 8'h00;
            if (count != 256 && n == 1) val = 8'hFF;
            offer(sel, val, ok);
            checks++;
            if (!ok) begin
                failures++;
                $display("[TB] FAIL loop_offer cpb=%0d %h: tx_ready got 0 expected 1", cpb, val);
                continue;
            end
            capture(sel, FRAME_BITS * cpb);
            rx = '0;
            for (int i = 0; i < 8; i++) rx[i] = tx_log[(i + 1) * cpb + cpb / 2];
            checks++;
            if (rx !== val) begin
                failures++;
                $display("[TB] FAIL loop_byte cpb=%0d: rx_byte got %h expected %h", cpb, rx, val);
            end
            checks++;
            if (tx_log[cpb/2] !== 1'b0 || tx_log[(FRAME_BITS - 1) * cpb + cpb / 2] !== 1'b1) begin
                failures++;
                $display("[TB] FAIL loop_framing cpb=%0d %h: start/stop got %b%b expected 01", cpb, val,
                         tx_log[cpb/2], tx_log[(FRAME_BITS - 1) * cpb + cpb / 2]);
            end
`ifdef UART_TX_PARITY_EN
            checks++;
            if (tx_log[9 * cpb + cpb / 2] !== ^val) begin
                failures++;
                $display("[TB] FAIL loop_parity cpb=%0d %h: got %b expected %b", cpb, val,
                         tx_log[9 * cpb + cpb / 2], ^val);
            end
`endif
        end
    endtask

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        test_reset();
        test_frames();
        test_back_to_back();
        test_ignore_midframe();
        test_reset_midframe();
        test_reset_priority();
        test_parity();
        test_loopback(1'b0, FAST_CPB, 256);
        test_loopback(1'b1, DEF_CPB, 10);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
